// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, then a held response.
// Optional address fault checking is compiled in with `define DMEM_ERR_CHECK_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       cnt;
  logic [3:0]       cnt_nxt;
  logic             accept;
  logic             commit_edge;
  logic             retire;
  logic             fault;

  logic             wr_q;
  logic [AW-1:0]    idx_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic             err_q;

  logic [31:0]      mem [DEPTH_WORDS];

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

`ifdef DMEM_ERR_CHECK_EN
  assign fault = (req_addr[1:0] != 2'b00) || (req_addr >= 32'(4 * DEPTH_WORDS));
`else
  // Byte offset and bits above the array are don't-care; the index wraps.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
  assign fault = 1'b0;
`endif

  assign accept      = (state == IDLE) && req_valid;
  assign commit_edge = (state == WAIT) && (cnt == 4'd0);
  assign retire      = (state == RESP) && resp_ready;

  assign req_ready   = (state == IDLE);
  assign resp_valid  = (state == RESP);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = WAIT;
          cnt_nxt   = 4'(WAIT_CYCLES);
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Acceptance stage: request fields are captured once and never re-read from the ports.
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= req_write;
      idx_q   <= req_addr[AW+1:2];
      wdata_q <= req_wdata;
      wstrb_q <= req_wstrb;
      err_q   <= fault;
    end
  end

  // Commit stage: the array changes only on the WAIT->RESP edge, never while reset is held.
  always_ff @(posedge clk) begin
    if (!reset && commit_edge && wr_q && !err_q) begin
      mem[idx_q] <= merge_bytes(mem[idx_q], wdata_q, wstrb_q);
    end
  end

  // Response stage: outputs are loaded on commit, held through the stall, cleared on retire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else if (commit_edge) begin
      resp_err   <= err_q;
      resp_rdata <= (!wr_q && !err_q) ? mem[idx_q] : 32'd0;
    end else if (retire) begin
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: default instance (WAIT_CYCLES=2) plus a zero-wait instance.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        z_req_valid, z_req_ready, z_req_write;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [3:0]  z_req_wstrb;
  logic        z_resp_valid, z_resp_ready;
  logic [31:0] z_resp_rdata;
  logic        z_resp_err;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_wstrb(z_req_wstrb),
    .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
    .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One transaction on the WAIT_CYCLES=2 instance; latency is counted in edges after acceptance.
  task automatic txn(input string tag, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s, input bit do_retire,
                     output logic [31:0] rd, output logic er);
    int lat;
    @(negedge clk);
    check({tag, "/req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = ~wr; req_addr = 32'hFFFF_FFFC;
    req_wdata = 32'h5A5A_5A5A; req_wstrb = 4'hF;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!resp_valid && lat < 40);
    check({tag, "/latency"}, 32'(lat), 32'd3);
    rd = resp_rdata;
    er = resp_err;
    if (do_retire) begin
      @(posedge clk); #1;
      check({tag, "/retired_valid"}, 32'(resp_valid), 32'd0);
      check({tag, "/retired_rdata"}, resp_rdata, 32'd0);
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    resp_ready = 1'b1;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_wstrb = '0;
    z_resp_ready = 1'b1;
    #12;
    check("reset/req_ready", 32'(req_ready), 32'd1);
    check("reset/resp_valid", 32'(resp_valid), 32'd0);
    check("reset/resp_rdata", resp_rdata, 32'd0);
    check("reset/resp_err", 32'(resp_err), 32'd0);
    check("reset/z_req_ready", 32'(z_req_ready), 32'd1);
    @(negedge clk); reset = 1'b0;

    // Known value in word 5, then a store to it aborted by reset while in WAIT.
    txn("st14", 1'b1, 32'h14, 32'h5555_5555, 4'hF, 1'b1, rd, er);
    check("st14/rdata", rd, 32'd0);
    check("st14/err", 32'(er), 32'd0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h14; req_wdata = 32'h1111_1111; req_wstrb = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("abort/req_ready", 32'(req_ready), 32'd1);
    check("abort/resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk); reset = 1'b0;
    txn("ld14", 1'b0, 32'h14, 32'h0, 4'h0, 1'b1, rd, er);
    check("ld14/rdata", rd, 32'h5555_5555);

    // Same pattern at 0x10, then the real store and its readback.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h1111_1111; req_wstrb = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    txn("st10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, rd, er);
    txn("ld10", 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, rd, er);
    check("ld10/rdata", rd, 32'hDEAD_BEEF);
    check("ld10/err", 32'(er), 32'd0);

    // Byte-enable merge.
    txn("st20a", 1'b1, 32'h20, 32'hAABB_CCDD, 4'hF, 1'b1, rd, er);
    txn("st20b", 1'b1, 32'h20, 32'h1122_3344, 4'h5, 1'b1, rd, er);
    txn("ld20", 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, rd, er);
    check("ld20/rdata", rd, 32'hAA22_CC44);

    // A store committed on entry to RESP survives a reset during the stall.
    resp_ready = 1'b0;
    txn("st18", 1'b1, 32'h18, 32'h7777_7777, 4'hF, 1'b0, rd, er);
    reset = 1'b1;
    #1;
    check("st18rst/resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk); reset = 1'b0; resp_ready = 1'b1;
    txn("ld18", 1'b0, 32'h18, 32'h0, 4'h0, 1'b1, rd, er);
    check("ld18/rdata", rd, 32'h7777_7777);

    // Word 0 and out-of-range / misaligned addresses.
    txn("st00", 1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, 1'b1, rd, er);
`ifdef DMEM_ERR_CHECK_EN
    txn("ld12", 1'b0, 32'h12, 32'h0, 4'h0, 1'b1, rd, er);
    check("ld12/err", 32'(er), 32'd1);
    check("ld12/rdata", rd, 32'd0);
    txn("st100", 1'b1, 32'h100, 32'h1234_5678, 4'hF, 1'b1, rd, er);
    check("st100/err", 32'(er), 32'd1);
    txn("ld00", 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, rd, er);
    check("ld00/rdata", rd, 32'hCAFE_F00D);
`else
    txn("ld100", 1'b0, 32'h100, 32'h0, 4'h0, 1'b1, rd, er);
    check("ld100/rdata", rd, 32'hCAFE_F00D);
    check("ld100/err", 32'(er), 32'd0);
    txn("ld12", 1'b0, 32'h12, 32'h0, 4'h0, 1'b1, rd, er);
    check("ld12/rdata", rd, 32'hDEAD_BEEF);
`endif

    // Response stall with a pending request held by the requester.
    resp_ready = 1'b0;
    txn("stall", 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rd, er);
    check("stall/rdata", rd, 32'hAA22_CC44);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_wdata = 32'h0; req_wstrb = 4'h0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall/resp_valid", 32'(resp_valid), 32'd1);
      check("stall/req_ready", 32'(req_ready), 32'd0);
      check("stall/hold_rdata", resp_rdata, 32'hAA22_CC44);
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1;
    check("stall/retire_valid", 32'(resp_valid), 32'd0);
    check("stall/retire_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    check("stall/next_accepted", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!resp_valid && lat < 40);
    check("stall/next_latency", 32'(lat), 32'd3);
    check("stall/next_rdata", resp_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;

    // Zero-wait instance: response visible right after the edge following acceptance.
    @(negedge clk);
    z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 32'h0; z_req_wdata = 32'h0BAD_F00D; z_req_wstrb = 4'hF;
    @(posedge clk); #1;
    z_req_valid = 1'b0;
    check("w0st/valid_at_accept", 32'(z_resp_valid), 32'd0);
    @(posedge clk); #1;
    check("w0st/valid_n1", 32'(z_resp_valid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    z_req_valid = 1'b1; z_req_write = 1'b0; z_req_addr = 32'h0;
    @(posedge clk); #1;
    z_req_valid = 1'b0;
    @(posedge clk); #1;
    check("w0ld/valid_n1", 32'(z_resp_valid), 32'd1);
    check("w0ld/rdata", z_resp_rdata, 32'h0BAD_F00D);
    @(posedge clk); #1;
    check("w0ld/retired", 32'(z_resp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
